mux4_rr_arbiter: RTL and testbench
==================================

MUX4_RR_ARBITER -- requirements
Module: mux4_rr_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 4, maximum consecutive grant cycles per owner; legal range 1..15.
REQ-002 clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, asynchronous, active-high.
REQ-004 req  input  4  request vector; bit i = requester i wants the shared mux.
REQ-005 a, b, c, d  input  2 each  requester 0..3 data.
REQ-006 gnt  output  4  one-hot grant, registered; all-zero when idle.
REQ-007 sel  output  2  mux select, registered; equals encoded index of gnt.
REQ-008 n_en  output  1  active-low mux enable, registered; 0 iff gnt nonzero.
REQ-009 y  output  2  selected requester data.
REQ-010 busy  output  1  1 iff state GRANT.

Function
REQ-011 The FSM SHALL have two states: IDLE, GRANT.
REQ-012 The rotate pointer ptr (2 bits) SHALL define priority order ptr, ptr+1, ptr+2, ptr+3 mod 4.
REQ-013 In IDLE with req nonzero at a rising edge, the block SHALL enter GRANT on that edge with gnt = first requester in pointer order, cnt = 0; 1-cycle latency req->gnt.
REQ-014 In IDLE with req == 0, gnt SHALL stay 0, n_en 1, sel held.
REQ-015 In GRANT, cnt SHALL increment each cycle while no release occurs.
REQ-016 Release SHALL occur at an edge where req[owner] == 0 or cnt == MAX_HOLD-1; a grant therefore lasts at most MAX_HOLD cycles.
REQ-017 On release, ptr SHALL become owner+1 mod 4 on the same edge.
REQ-018 On release, re-arbitration SHALL occur on the same edge using the updated pointer order (owner lowest priority); no bubble cycle when another request is pending.
REQ-019 On release with owner the only requester still asserting (hold limit hit), owner SHALL be re-granted with cnt = 0.
REQ-020 On release with req == 0, the FSM SHALL return to IDLE with gnt = 0, n_en = 1.
REQ-021 Requests from non-owners during GRANT SHALL NOT preempt the owner.
REQ-022 y SHALL equal a/b/c/d per sel when n_en == 0, and 2'b00 when n_en == 1; combinational from registered sel/n_en.
REQ-023 gnt SHALL never have more than one bit set; sel SHALL always match gnt while nonzero.
REQ-024 With MAX_HOLD == 1, each grant SHALL last exactly one cycle and rotate whenever others request.

Reset
REQ-025 While rst is high: state IDLE, gnt 0, sel 0, n_en 1, busy 0, y 0, ptr 0, cnt 0, asynchronously.
REQ-026 Reset asserted mid-grant SHALL drop gnt immediately; first arbitration after release SHALL start from ptr 0.

Structure
REQ-027 State encodings (IDLE, GRANT) and the MAX_HOLD default SHALL live in a shared package/header mux_arb_pkg.
REQ-028 The datapath SHALL be one sub-module instance of the team's mux4_1 (2-bit four-input mux with select and active-low enable), driven by sel and n_en.
REQ-029 Priority selection SHALL be a single combinational function/block; the FSM, ptr and cnt in one sequential process.

Verification
REQ-030 Reset then req=4'b0100, c=2'b11 -> next cycle gnt=4'b0100, sel=2, n_en=0, y=2'b11, busy=1.
REQ-031 req=4'b1111 held, MAX_HOLD=4 -> gnt sequence 0001 x4, 0010 x4, 0100 x4, 1000 x4, 0001, no gaps.
REQ-032 req=4'b0001 held alone, MAX_HOLD=4 -> gnt stays 0001 continuously, cnt wraps 0..3, no idle cycle.
REQ-033 Owner 2 drops req after 2 cycles, req[0] pending -> gnt 0100 for 2 cycles then 0001 next edge; ptr=3.
REQ-034 rst pulsed during grant to requester 3 -> gnt=0, n_en=1, y=0 immediately; after release with req=4'b1001, grant goes to 0 first.
REQ-035 All scenarios -> assertions: gnt one-hot-or-zero, n_en == (gnt == 0), y == 0 whenever n_en == 1.

Source files
------------

// File: rtl/mux_arb_pkg.sv
// Shared types and constants for the four-way round-robin mux arbiter.
package mux_arb_pkg;

   localparam int unsigned NUM_REQ      = 4;
   localparam int unsigned IDX_W        = 2;
   localparam int unsigned DATA_W       = 2;
   localparam int unsigned CNT_W        = 4;
   localparam int unsigned MAX_HOLD_DEF = 4;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } arbState_t;

   typedef struct packed {
      logic             found;
      logic [IDX_W-1:0] idx;
   } pick_t;

   // First asserted requester in the order ptr, ptr+1, ptr+2, ptr+3 (mod 4).
   function automatic pick_t pickNext(input logic [NUM_REQ-1:0] reqVec,
                                      input logic [IDX_W-1:0]   ptrVal);
      pick_t            p;
      logic [IDX_W-1:0] cand;
      p.found = 1'b0;
      p.idx   = ptrVal;
      // Walk from lowest to highest priority so the last hit wins.
      for (int i = 3; i >= 0; i--) begin
         cand = ptrVal + IDX_W'(i);
         if (reqVec[cand]) begin
            p.found = 1'b1;
            p.idx   = cand;
         end
      end
      return p;
   endfunction

endpackage

// File: rtl/mux4_1.sv
// Two-bit, four-input mux with active-low enable; output forced to zero when disabled.
module mux4_1
   import mux_arb_pkg::*;
(
   input  logic [IDX_W-1:0]  sel,
   input  logic              nEn,
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic [DATA_W-1:0] c,
   input  logic [DATA_W-1:0] d,
   output logic [DATA_W-1:0] y
);

   always_comb begin
      y = '0;
      if (!nEn) begin
         case (sel)
            2'd0:    y = a;
            2'd1:    y = b;
            2'd2:    y = c;
            default: y = d;
         endcase
      end
   end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin arbiter owning a shared four-input mux, with a per-owner hold limit
// and same-edge re-arbitration on release.
module mux4_rr_arbiter
   import mux_arb_pkg::*;
#(
   parameter int unsigned MAX_HOLD = MAX_HOLD_DEF
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_REQ-1:0]  req,
   input  logic [DATA_W-1:0]   a,
   input  logic [DATA_W-1:0]   b,
   input  logic [DATA_W-1:0]   c,
   input  logic [DATA_W-1:0]   d,
   output logic [NUM_REQ-1:0]  gnt,
   output logic [IDX_W-1:0]    sel,
   output logic                n_en,
   output logic [DATA_W-1:0]   y,
   output logic                busy
);

   arbState_t          state, stateNext;
   logic [IDX_W-1:0]   ptr, ptrNext;
   logic [CNT_W-1:0]   cnt, cntNext;
   logic [NUM_REQ-1:0] gntNext;
   logic [IDX_W-1:0]   selNext;
   logic               nEnNext;
   logic               relNow;
   logic [IDX_W-1:0]   ptrAfterRel;
   pick_t              pickIdle, pickRel;

   // Priority picks: current pointer order, and the order after the owner releases.
   assign ptrAfterRel = sel + IDX_W'(1);
   assign pickIdle    = pickNext(req, ptr);
   assign pickRel     = pickNext(req, ptrAfterRel);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         gnt   <= '0;
         sel   <= '0;
         n_en  <= 1'b1;
         ptr   <= '0;
         cnt   <= '0;
      end else begin
         state <= stateNext;
         gnt   <= gntNext;
         sel   <= selNext;
         n_en  <= nEnNext;
         ptr   <= ptrNext;
         cnt   <= cntNext;
      end
   end

   always_comb begin
      stateNext = state;
      gntNext   = gnt;
      selNext   = sel;
      nEnNext   = n_en;
      ptrNext   = ptr;
      cntNext   = cnt;
      relNow    = 1'b0;

      case (state)
         IDLE: begin
            if (pickIdle.found) begin
               stateNext = GRANT;
               gntNext   = NUM_REQ'(1) << pickIdle.idx;
               selNext   = pickIdle.idx;
               nEnNext   = 1'b0;
               cntNext   = '0;
            end else begin
               gntNext = '0;
               nEnNext = 1'b1;
            end
         end

         GRANT: begin
            relNow = !req[sel] || (cnt == CNT_W'(MAX_HOLD - 1));
            if (relNow) begin
               // Owner drops to lowest priority; hand over on the same edge.
               ptrNext = ptrAfterRel;
               cntNext = '0;
               if (pickRel.found) begin
                  gntNext = NUM_REQ'(1) << pickRel.idx;
                  selNext = pickRel.idx;
                  nEnNext = 1'b0;
               end else begin
                  stateNext = IDLE;
                  gntNext   = '0;
                  nEnNext   = 1'b1;
               end
            end else begin
               cntNext = cnt + CNT_W'(1);
            end
         end

         default: begin
            stateNext = IDLE;
            gntNext   = '0;
            nEnNext   = 1'b1;
         end
      endcase
   end

   assign busy = (state == GRANT);

   mux4_1 uMux (
      .sel (sel),
      .nEn (n_en),
      .a   (a),
      .b   (b),
      .c   (c),
      .d   (d),
      .y   (y)
   );

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Directed scoreboard bench for the round-robin mux arbiter.
module tb_mux4_rr_arbiter;

   localparam int unsigned MAX_HOLD = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] req;
   logic [1:0] a, b, c, d;
   logic [3:0] gnt;
   logic [1:0] sel;
   logic       n_en;
   logic [1:0] y;
   logic       busy;

   mux4_rr_arbiter #(.MAX_HOLD(MAX_HOLD)) dut (
      .clk  (clk),
      .rst  (rst),
      .req  (req),
      .a    (a),
      .b    (b),
      .c    (c),
      .d    (d),
      .gnt  (gnt),
      .sel  (sel),
      .n_en (n_en),
      .y    (y),
      .busy (busy)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] gnt;
      logic [1:0] sel;
      logic       nEn;
      logic [1:0] y;
      logic       busy;
      string      tag;
   } exp_t;

   exp_t sbQ[$];
   int   nChecks = 0;
   int   nPass   = 0;

   task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] want);
      nChecks++;
      assert (obs === want) nPass++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
   endtask

   function automatic logic [1:0] dataOf(input logic [1:0] s);
      case (s)
         2'd0:    return a;
         2'd1:    return b;
         2'd2:    return c;
         default: return d;
      endcase
   endfunction

   // Queue what the outputs must look like after the next rising edge.
   task automatic expectAfterEdge(input logic [3:0] g, input logic [1:0] s, input string tag);
      exp_t e;
      e.gnt  = g;
      e.sel  = s;
      e.nEn  = (g == 4'b0000);
      e.y    = e.nEn ? 2'b00 : dataOf(s);
      e.busy = (g != 4'b0000);
      e.tag  = tag;
      sbQ.push_back(e);
   endtask

   task automatic checkInvariants(input string tag);
      chk({tag, "_onehot"}, 4'($countones(gnt) <= 1), 4'd1);
      chk({tag, "_nen_vs_gnt"}, 4'(n_en), 4'(gnt == 4'b0000));
      if (n_en) chk({tag, "_y_off"}, 4'(y), 4'd0);
   endtask

   // Advance one edge, then pop and compare against the scoreboard.
   task automatic cycle();
      exp_t e;
      @(posedge clk);
      #1;
      nChecks++;
      if (sbQ.size() == 0) begin
         $error("FAIL scoreboard_empty: observed 0 entries expected 1");
      end else begin
         nPass++;
         e = sbQ.pop_front();
         chk({e.tag, "_gnt"}, gnt, e.gnt);
         chk({e.tag, "_sel"}, 4'(sel), 4'(e.sel));
         chk({e.tag, "_nen"}, 4'(n_en), 4'(e.nEn));
         chk({e.tag, "_y"}, 4'(y), 4'(e.y));
         chk({e.tag, "_busy"}, 4'(busy), 4'(e.busy));
         checkInvariants(e.tag);
      end
   endtask

   // Asynchronous reset pulse away from the clock edge, checking outputs while held.
   task automatic rstPulse(input string tag);
      rst = 1'b1;
      #1;
      chk({tag, "_gnt"}, gnt, 4'b0000);
      chk({tag, "_sel"}, 4'(sel), 4'd0);
      chk({tag, "_nen"}, 4'(n_en), 4'd1);
      chk({tag, "_busy"}, 4'(busy), 4'd0);
      chk({tag, "_y"}, 4'(y), 4'd0);
      chk({tag, "_ptr"}, 4'(dut.ptr), 4'd0);
      chk({tag, "_cnt"}, 4'(dut.cnt), 4'd0);
      #1;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      req = 4'b0000;
      a = 2'b01; b = 2'b10; c = 2'b11; d = 2'b10;

      #11;
      rstPulse("reset");

      // Single request from requester 2.
      req = 4'b0100;
      expectAfterEdge(4'b0100, 2'd2, "first_grant");
      cycle();
      req = 4'b0000;
      expectAfterEdge(4'b0000, 2'd2, "drop_to_idle");
      cycle();
      expectAfterEdge(4'b0000, 2'd2, "idle_hold");
      cycle();

      // All requesting: four cycles per owner, rotating without gaps.
      rstPulse("rst_rot");
      req = 4'b1111;
      for (int k = 0; k < 17; k++) begin
         logic [1:0] own;
         own = (k < 16) ? 2'(k / 4) : 2'd0;
         expectAfterEdge(4'(4'b0001 << own), own, "rotate");
         cycle();
      end
      req = 4'b0000;
      expectAfterEdge(4'b0000, 2'd0, "rotate_idle");
      cycle();

      // Lone requester is re-granted at the hold limit with no idle cycle.
      rstPulse("rst_alone");
      req = 4'b0001;
      for (int k = 0; k < 10; k++) begin
         expectAfterEdge(4'b0001, 2'd0, "alone");
         cycle();
         chk("alone_cnt", 4'(dut.cnt), 4'(k % MAX_HOLD));
      end
      req = 4'b0000;
      expectAfterEdge(4'b0000, 2'd0, "alone_idle");
      cycle();

      // Owner 2 releases early with requester 0 pending; no preemption meanwhile.
      rstPulse("rst_early");
      req = 4'b0100;
      expectAfterEdge(4'b0100, 2'd2, "early_own2_a");
      cycle();
      req = 4'b0101;
      expectAfterEdge(4'b0100, 2'd2, "early_own2_b");
      cycle();
      req = 4'b0001;
      expectAfterEdge(4'b0001, 2'd0, "early_handover");
      cycle();
      chk("early_ptr", 4'(dut.ptr), 4'd3);
      req = 4'b0011;
      expectAfterEdge(4'b0001, 2'd0, "nopreempt_1");
      cycle();
      expectAfterEdge(4'b0001, 2'd0, "nopreempt_2");
      cycle();
      expectAfterEdge(4'b0001, 2'd0, "nopreempt_3");
      cycle();
      expectAfterEdge(4'b0010, 2'd1, "hold_limit_pass");
      cycle();
      req = 4'b0000;
      expectAfterEdge(4'b0000, 2'd1, "early_idle");
      cycle();

      // Reset mid-grant to requester 3, then arbitration restarts from pointer 0.
      rstPulse("rst_mid_pre");
      req = 4'b1000;
      expectAfterEdge(4'b1000, 2'd3, "own3_a");
      cycle();
      expectAfterEdge(4'b1000, 2'd3, "own3_b");
      cycle();
      rstPulse("rst_mid");
      req = 4'b1001;
      expectAfterEdge(4'b0001, 2'd0, "post_rst_grant");
      cycle();
      req = 4'b0000;
      expectAfterEdge(4'b0000, 2'd0, "final_idle");
      cycle();

      nChecks++;
      assert (sbQ.size() == 0) nPass++;
      else $error("FAIL scoreboard_drain: observed %0d entries expected 0", sbQ.size());

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end

   initial begin
      #20000;
      $display("FAIL timeout: observed no finish expected finish");
      $fatal(1, "timeout");
   end

endmodule
